view_ray_gen: RTL and testbench
===============================

// Module: view_ray_gen
// PURPOSE
//  Parametrised, handshaked successor of the per-pixel view-ray generator.
//  Takes view normal d=(dx,dy,dz), view distance d0 and canvas location (col,row).
//  Produces ray = (d0*dx + x*dy)/|d|, (d0*dy + x*dx)/|d|, y, with x=col-COL_MID and y=ROW_MID-row.
//  |d| is floor-sqrt computed iteratively; the two quotients share one restoring divider.
//  Sits between the canvas scan counter and the ray/object intersection stage.
// PARAMETERS
//  COORD_W   11  signed width of dx, dy, out_x, out_y
//  Z_W       9   signed width of dz, out_z
//  DIST_W    8   unsigned width of view_dist
//  COL_BITS  7   canvas column index width
//  ROW_BITS  6   canvas row index width
//  COL_MID   64  column mapped to x=0
//  ROW_MID   32  row mapped to y=0
//  NUM_W  derived = DIST_W+COORD_W+2; signed numerator width
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  in_valid   in   1   request valid
//  in_ready   out  1   block idle, can accept
//  view_normal in  2*COORD_W+Z_W  {dx,dy,dz}, two's complement
//  view_dist  in   DIST_W      d0, unsigned
//  view_loc   in   COL_BITS+ROW_BITS  {col,row}, unsigned
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  view_out   out  2*COORD_W+Z_W  {out_x,out_y,out_z}
//  out_err    out  1   |d|==0 for this result
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, in_ready=1, out_valid=0, out_err=0, view_out=all ones.
//  Accept: in_valid&&in_ready at a rising edge latches all inputs and enters SQRT.
//   in_ready=1 only in IDLE, so no new request is taken while busy or holding a result.
//  Input hold: inputs are not sampled after acceptance; they may change freely.
//  FSM: IDLE -> SQRT -> DIVX -> DIVY -> DONE -> IDLE.
//  SQRT: COORD_W+1 cycles, one root bit per cycle.
//   Result is floor(sqrt(dx^2+dy^2+dz^2)), unsigned, COORD_W+1 bits.
//   Zero root: go straight to DONE with out_x=out_y=all ones, out_z per rule below, out_err=1.
//  Numerators, computed at full width in NUM_W signed, sign-extended, no truncation:
//   num_x = d0*dx + x*dy;  num_y = d0*dy + x*dx.
//  DIVX, DIVY: NUM_W cycles each. Restoring divide of |num| by the root.
//   Quotient sign = sign(num); truncation toward zero.
//   Quotient outside the signed COORD_W range saturates to max/min; out_err stays 0.
//  out_z = ROW_MID - row, sign-extended/truncated to Z_W; no divide.
//  Latency with defaults: accept edge to out_valid = 1 + 12 + 21 + 21 = 55 cycles.
//   Zero-length case: 13 cycles.
//  DONE: out_valid=1 and view_out/out_err stable until out_valid&&out_ready.
//   On that edge, out_valid->0 and state->IDLE; in_ready=1 on the next cycle.
//  view_out keeps its last value after the handshake (not cleared).
//  Reset mid-operation: abort immediately to reset values; no partial result is emitted.
//  No combinational path from in_valid or out_ready to any output.
// TESTING
//  1 dx=100,dy=0,dz=0,d0=50,col=64,row=32 -> out_x=50, out_y=0, out_z=0, err=0, latency 55.
//  2 dx=3,dy=4,dz=0,d0=10,col=69,row=0 -> |d|=5, out_x=10, out_y=11, out_z=32.
//  3 dx=-100,dy=0,dz=0,d0=50,col=64,row=40 -> out_x=-50 (11'h7CE), out_y=0, out_z=-8 (9'h1F8).
//  4 d=(0,0,0), any d0/loc -> out_err=1, out_x=out_y=11'h7FF, out_valid after 13 cycles.
//  5 out_ready low 20 cycles in DONE -> view_out stable, in_ready=0, in_valid ignored;
//    then ready -> one transfer.
//  6 rst pulsed low during DIVX -> outputs at reset values at once;
//    next request gives the correct result of test 1.

Source files
------------

// File: rtl/view_ray_gen.sv
// Per-pixel view-ray generator: latches one request, computes floor-sqrt of |d|,
// then two signed quotients through a shared restoring divider, and holds the result until taken.
module view_ray_gen #(
  parameter int COORD_W  = 11,
  parameter int Z_W      = 9,
  parameter int DIST_W   = 8,
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 6,
  parameter int COL_MID  = 64,
  parameter int ROW_MID  = 32,
  parameter int NUM_W    = DIST_W + COORD_W + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*COORD_W+Z_W-1:0]      view_normal,
  input  logic [DIST_W-1:0]             view_dist,
  input  logic [COL_BITS+ROW_BITS-1:0]  view_loc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*COORD_W+Z_W-1:0]      view_out,
  output logic                          out_err
);

  localparam int RT_W  = COORD_W + 1;
  localparam int SQ_W  = 2 * RT_W;
  localparam int REM_W = RT_W + 1;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [NUM_W-1:0] POS_LIM = NUM_W'(2**(COORD_W-1) - 1);
  localparam logic [NUM_W-1:0] NEG_LIM = NUM_W'(2**(COORD_W-1));

  typedef enum logic [2:0] {IDLE, SQRT, DIVX, DIVY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               prep;

  logic signed [COORD_W-1:0] dx_p0, dy_p0;
  logic signed [Z_W-1:0]     dz_p0;
  logic [DIST_W-1:0]         d0_p0;
  logic [COL_BITS-1:0]       col_p0;
  logic [ROW_BITS-1:0]       row_p0;

  logic [SQ_W-1:0]           sumsq_p1;
  logic signed [NUM_W-1:0]   num_x_p1, num_y_p1;

  logic [RT_W-1:0]           root_r;
  logic [NUM_W-1:0]          dvd_r, q_r;
  logic [REM_W-1:0]          rem_r;
  logic signed [COORD_W-1:0] qx_r;

  // Apply the numerator sign to the unsigned quotient, clamping to the signed COORD_W range.
  function automatic logic signed [COORD_W-1:0] sat_quot(input logic [NUM_W-1:0] mag,
                                                          input logic neg);
    logic [COORD_W-1:0] m;
    m = mag[COORD_W-1:0];
    if (!neg) sat_quot = (mag > POS_LIM) ? POS_LIM[COORD_W-1:0] : m;
    else      sat_quot = (mag > NEG_LIM) ? NEG_LIM[COORD_W-1:0] : -m;
  endfunction

  function automatic logic [NUM_W-1:0] mag_of(input logic signed [NUM_W-1:0] v);
    mag_of = v[NUM_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic signed [Z_W-1:0] row_to_z(input logic [ROW_BITS-1:0] row);
    row_to_z = Z_W'(ROW_MID - int'(row));
  endfunction

  logic signed [SQ_W-1:0]  sx, sy, sz;
  logic [SQ_W-1:0]         sq_c;
  logic signed [NUM_W-1:0] d0_e, dx_e, dy_e, x_e, nx_c, ny_c;
  logic [RT_W-1:0]         trial, root_nxt;
  logic [SQ_W-1:0]         tsq;
  logic [REM_W-1:0]        rem_sh, rem_nxt;
  logic                    rem_ge;
  logic [NUM_W-1:0]        q_nxt;

  always_comb begin
    sx   = SQ_W'(dx_p0);
    sy   = SQ_W'(dy_p0);
    sz   = SQ_W'(dz_p0);
    sq_c = $unsigned(sx * sx + sy * sy + sz * sz);

    d0_e = NUM_W'($signed({1'b0, d0_p0}));
    dx_e = NUM_W'(dx_p0);
    dy_e = NUM_W'(dy_p0);
    x_e  = NUM_W'($signed({1'b0, col_p0})) - NUM_W'(COL_MID);
    nx_c = d0_e * dx_e + x_e * dy_e;
    ny_c = d0_e * dy_e + x_e * dx_e;

    trial    = root_r | (RT_W'(1) << cnt);
    tsq      = {{RT_W{1'b0}}, trial} * {{RT_W{1'b0}}, trial};
    root_nxt = (tsq <= sumsq_p1) ? trial : root_r;

    rem_sh  = {rem_r[REM_W-2:0], dvd_r[NUM_W-1]};
    rem_ge  = (rem_sh >= {1'b0, root_r});
    rem_nxt = rem_ge ? (rem_sh - {1'b0, root_r}) : rem_sh;
    q_nxt   = {q_r[NUM_W-2:0], rem_ge};
  end

  // Control: state, handshakes and the registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      prep      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      view_out  <= '1;
    end else begin
      unique case (state)
        IDLE: if (in_valid && in_ready) begin
          state    <= SQRT;
          prep     <= 1'b1;
          in_ready <= 1'b0;
        end
        SQRT: begin
          if (prep) begin
            prep <= 1'b0;
            cnt  <= CNT_W'(RT_W - 1);
          end else if (cnt == '0) begin
            if (root_nxt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              view_out  <= {{(2*COORD_W){1'b1}}, row_to_z(row_p0)};
            end else begin
              state <= DIVX;
              cnt   <= CNT_W'(NUM_W - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIVX: begin
          if (cnt == '0) begin
            state <= DIVY;
            cnt   <= CNT_W'(NUM_W - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIVY: begin
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            view_out  <= {qx_r, sat_quot(q_nxt, num_y_p1[NUM_W-1]), row_to_z(row_p0)};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: request capture, operand prep, root bits, divider shifts.
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: if (in_valid && in_ready) begin
        {dx_p0, dy_p0, dz_p0} <= view_normal;
        d0_p0                 <= view_dist;
        {col_p0, row_p0}      <= view_loc;
      end
      SQRT: begin
        if (prep) begin
          sumsq_p1 <= sq_c;
          num_x_p1 <= nx_c;
          num_y_p1 <= ny_c;
          root_r   <= '0;
        end else begin
          root_r <= root_nxt;
          dvd_r  <= mag_of(num_x_p1);
          rem_r  <= '0;
          q_r    <= '0;
        end
      end
      DIVX: begin
        if (cnt == '0) begin
          qx_r  <= sat_quot(q_nxt, num_x_p1[NUM_W-1]);
          dvd_r <= mag_of(num_y_p1);
          rem_r <= '0;
          q_r   <= '0;
        end else begin
          dvd_r <= dvd_r << 1;
          rem_r <= rem_nxt;
          q_r   <= q_nxt;
        end
      end
      DIVY: begin
        dvd_r <= dvd_r << 1;
        rem_r <= rem_nxt;
        q_r   <= q_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_view_ray_gen.sv
// Directed bench for view_ray_gen: table of hand-computed rays plus hold and mid-op reset sequences.
module tb_view_ray_gen;

  localparam int COORD_W  = 11;
  localparam int Z_W      = 9;
  localparam int DIST_W   = 8;
  localparam int COL_BITS = 7;
  localparam int ROW_BITS = 6;
  localparam int NORM_W   = 2*COORD_W + Z_W;
  localparam int LOC_W    = COL_BITS + ROW_BITS;

  logic              clk, rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [NORM_W-1:0] view_normal, view_out;
  logic [DIST_W-1:0] view_dist;
  logic [LOC_W-1:0]  view_loc;

  int tests = 0;
  int fails = 0;

  view_ray_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .view_normal(view_normal), .view_dist(view_dist), .view_loc(view_loc),
    .out_valid(out_valid), .out_ready(out_ready), .view_out(view_out), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dx, dy, dz, d0, col, row;
    int ex, ey, ez;
    int err;
    int lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NORM_W-1:0] pack(input int x, input int y, input int z);
    logic [COORD_W-1:0] px, py;
    logic [Z_W-1:0]     pz;
    px = COORD_W'(x);
    py = COORD_W'(y);
    pz = Z_W'(z);
    return {px, py, pz};
  endfunction

  task automatic drive(input vec_t v);
    view_normal = {COORD_W'(v.dx), COORD_W'(v.dy), Z_W'(v.dz)};
    view_dist   = DIST_W'(v.d0);
    view_loc    = {COL_BITS'(v.col), ROW_BITS'(v.row)};
  endtask

  task automatic start_req(input vec_t v, input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    view_normal = NORM_W'($urandom);
    view_dist   = DIST_W'($urandom);
    view_loc    = LOC_W'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    logic [NORM_W-1:0] expv;
    expv = pack(v.ex, v.ey, v.ez);
    start_req(v, tag);
    wait_valid(lat);
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_view_out"}, view_out, expv);
    check({tag, "_err"}, out_err, v.err);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
    check({tag, "_view_keep"}, view_out, expv);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, bad, extra;
    logic [NORM_W-1:0] held;

    //            dx    dy    dz   d0  col row   ex    ey   ez err lat
    vecs[0] = '{  100,    0,    0,  50, 64, 32,   50,    0,   0, 0, 55};
    vecs[1] = '{    3,    4,    0,  10, 69,  0,   10,   11,  32, 0, 55};
    vecs[2] = '{ -100,    0,    0,  50, 64, 40,  -50,    0,  -8, 0, 55};
    vecs[3] = '{    0,    0,    0,  77, 10,  5,   -1,   -1,  27, 1, 13};
    vecs[4] = '{    0,   -7,    0,  20, 60, 10,    4,  -20,  22, 0, 55};
    vecs[5] = '{   -3,    4,   12,   7, 61, 50,   -2,    2, -18, 0, 55};
    vecs[6] = '{   10,   10,   10, 100, 64,  0,   58,   58,  32, 0, 55};
    vecs[7] = '{-1024,-1024, -256, 255,  0, 63, -133, -133, -31, 0, 55};
    vecs[8] = '{    0,    0,    5,   9, 64, 32,    0,    0,   0, 0, 55};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    view_normal = '0; view_dist = '0; view_loc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_err", out_err, 0);
    check("reset_view_out", view_out, {NORM_W{1'b1}});
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Result held under back-pressure while a new request is presented.
    start_req(vecs[0], "hold");
    wait_valid(lat);
    check("hold_latency", lat, 55);
    held = view_out;
    check("hold_view_out", held, pack(50, 0, 0));
    bad = 0;
    @(negedge clk);
    drive(vecs[1]);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (view_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("hold_stable_cycles_bad", bad, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_valid_drop", out_valid, 0);
    check("hold_ready_back", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) extra++;
    end
    check("hold_single_transfer", extra, 0);
    check("hold_view_keep", view_out, held);

    // Asynchronous reset while the X quotient is being divided.
    start_req(vecs[0], "midrst");
    repeat (25) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_view_out", view_out, {NORM_W{1'b1}});
    check("midrst_out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
